// File: rtl/timer_arbiter.sv
// Round-robin owner of a shared 64-bit one-shot timer: programs delay, start,
// waits for completion or abort, then returns a done pulse to the owner.
module timer_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*64-1:0]      req_delay,
  input  logic [NUM_REQ-1:0]         abort,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       aborted,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic [1:0]                 avm_address,
  output logic                       avm_write,
  output logic [31:0]                avm_writedata,
  output logic [3:0]                 avm_byteenable,
  input  logic                       irq
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, WR_START, WAIT, WR_STOP, WR_CLR, DONE
  } state_t;

  state_t         state;
  logic [OW-1:0]  last_owner;
  logic [OW-1:0]  win_idx;
  logic [OW-1:0]  cand;
  logic           win_valid;
  logic [63:0]    delay_q;
  logic [63:0]    win_delay;

  // Search downward so the requester closest after last_owner is taken last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = OW'((32'(last_owner) + 32'(i)) % NUM_REQ);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    win_delay = req_delay[64*win_idx +: 64];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OW'(NUM_REQ - 1);
      owner      <= '0;
      delay_q    <= '0;
      gnt        <= '0;
      done       <= '0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gnt     <= '0;
      done    <= '0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner   <= win_idx;
            delay_q <= win_delay;
            gnt     <= NUM_REQ'(1) << win_idx;
            busy    <= 1'b1;
            // A zero count would never start the timer, so finish immediately.
            if (win_delay == 64'd0) begin
              state <= DONE;
              done  <= NUM_REQ'(1) << win_idx;
            end else begin
              state <= WR_LO;
            end
          end
        end
        WR_LO:    state <= WR_HI;
        WR_HI:    state <= WR_START;
        WR_START: state <= WAIT;
        WAIT: begin
          if (irq) begin
            state <= WR_CLR;
          end else if (abort[owner]) begin
            state <= WR_STOP;
          end
        end
        WR_STOP: begin
          state   <= DONE;
          done    <= NUM_REQ'(1) << owner;
          aborted <= 1'b1;
        end
        WR_CLR: begin
          state <= DONE;
          done  <= NUM_REQ'(1) << owner;
        end
        DONE: begin
          last_owner <= owner;
          owner      <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Timer bus writes decode directly from the state register.
  always_comb begin
    avm_write      = 1'b0;
    avm_address    = 2'd0;
    avm_writedata  = 32'd0;
    avm_byteenable = 4'h0;
    case (state)
      WR_LO: begin
        avm_write      = 1'b1;
        avm_address    = 2'd1;
        avm_writedata  = delay_q[31:0];
        avm_byteenable = 4'hF;
      end
      WR_HI: begin
        avm_write      = 1'b1;
        avm_address    = 2'd2;
        avm_writedata  = delay_q[63:32];
        avm_byteenable = 4'hF;
      end
      WR_START: begin
        avm_write      = 1'b1;
        avm_writedata  = 32'h1;
        avm_byteenable = 4'h1;
      end
      WR_STOP: begin
        avm_write      = 1'b1;
        avm_writedata  = 32'h2;
        avm_byteenable = 4'h1;
      end
      WR_CLR: begin
        avm_write      = 1'b1;
        avm_byteenable = 4'h1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter with a behavioural one-shot timer model.
module tb_timer_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [255:0] req_delay;
  logic [3:0]   abort;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic         aborted;
  logic         busy;
  logic [1:0]   owner;
  logic [1:0]   avm_address;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] exp_wr[$];
  logic [3:0]  exp_gnt[$];
  logic [4:0]  exp_done[$];

  logic [63:0] tcnt;
  logic        trun;
  logic        tcomplete;
  logic        force3;

  timer_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_delay(req_delay), .abort(abort),
    .gnt(gnt), .done(done), .aborted(aborted), .busy(busy), .owner(owner),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .irq(irq)
  );

  always #5 clk = ~clk;

  // Timer: completes one cycle after the count reaches 1; stop zeroes it silently.
  always @(posedge clk) begin
    if (reset) begin
      tcnt <= '0; trun <= 1'b0; tcomplete <= 1'b0;
    end else if (avm_write) begin
      case (avm_address)
        2'd1: tcnt[31:0]  <= avm_writedata;
        2'd2: tcnt[63:32] <= avm_writedata;
        default: begin
          tcomplete <= 1'b0;
          if (avm_writedata[1]) begin
            trun <= 1'b0; tcnt <= '0;
          end else if (avm_writedata[0] && (tcnt != 0 || force3)) begin
            trun <= 1'b1;
            if (force3) tcnt <= 64'd3;
          end
        end
      endcase
    end else if (trun) begin
      if (tcnt == 64'd1) begin
        tcnt <= '0; trun <= 1'b0; tcomplete <= 1'b1;
      end else begin
        tcnt <= tcnt - 64'd1;
      end
    end
  end
  assign irq = tcomplete;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_writes(input logic [63:0] d, input logic stop);
    exp_wr.push_back({2'd1, d[31:0], 4'hF});
    exp_wr.push_back({2'd2, d[63:32], 4'hF});
    exp_wr.push_back({2'd0, 32'h1, 4'h1});
    exp_wr.push_back({2'd0, stop ? 32'h2 : 32'h0, 4'h1});
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (avm_write) begin
      check("wr_pending", 64'(exp_wr.size() > 0), 64'(1));
      if (exp_wr.size() > 0)
        check("wr", 64'({avm_address, avm_writedata, avm_byteenable}), 64'(exp_wr.pop_front()));
    end else if ({avm_address, avm_writedata, avm_byteenable} != 38'd0) begin
      check("bus_idle", 64'({avm_address, avm_writedata, avm_byteenable}), 64'(0));
    end
    if (gnt != 4'd0) begin
      check("gnt_pending", 64'(exp_gnt.size() > 0), 64'(1));
      if (exp_gnt.size() > 0) check("gnt", 64'(gnt), 64'(exp_gnt.pop_front()));
    end
    if (done != 4'd0) begin
      check("done_pending", 64'(exp_done.size() > 0), 64'(1));
      if (exp_done.size() > 0) check("done", 64'({done, aborted}), 64'(exp_done.pop_front()));
    end else if (aborted) begin
      check("aborted_stray", 64'(aborted), 64'(0));
    end
  end

  task automatic wait_gnt(input int idx, output int n);
    n = 0;
    while (!gnt[idx] && n < 20) begin tick(); n++; end
  endtask

  task automatic wait_done(input int idx, output int n);
    n = 0;
    while (!done[idx] && n < 5000) begin tick(); n++; end
  endtask

  task automatic do_job(input logic [3:0] mask, input int idx, input logic [63:0] d, input int lat);
    int n;
    req_delay[64*idx +: 64] = d;
    exp_gnt.push_back(4'(1) << idx);
    if (d != 64'd0) push_writes(d, 1'b0);
    exp_done.push_back({4'(1) << idx, 1'b0});
    req = req | mask;
    wait_gnt(idx, n);
    check("gnt_lat", 64'(n), 64'(1));
    check("owner", 64'(owner), 64'(idx));
    check("busy", 64'(busy), 64'(1));
    req[idx] = 1'b0;
    wait_done(idx, n);
    check("done_lat", 64'(n), 64'(lat));
    check("cmpl_clear", 64'(tcomplete), 64'(0));
    tick();
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_owner", 64'(owner), 64'(0));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_owner"}, 64'(owner), 64'(0));
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_aborted"}, 64'(aborted), 64'(0));
    check({tag, "_bus"}, 64'({avm_write, avm_address, avm_writedata, avm_byteenable}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int order[5];
    logic irq_hit;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; abort = '0; req_delay = '0; force3 = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    // Fairness: all four held, each re-raised after its done.
    for (int i = 0; i < 4; i++) req_delay[64*i +: 64] = 64'd5;
    for (int k = 0; k < 5; k++) begin
      exp_gnt.push_back(4'(1) << order[k]);
      push_writes(64'd5, 1'b0);
      exp_done.push_back({4'(1) << order[k], 1'b0});
    end
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (gnt == 4'd0 && n < 50) begin tick(); n++; end
      check("fair_gap", 64'(n), 64'((k == 0) ? 1 : 2));
      if (k == 4) req = 4'h0;
      else req[order[k]] = 1'b0;
      n = 0;
      while (done == 4'd0 && n < 100) begin tick(); n++; end
      check("fair_done_lat", 64'(n), 64'(10));
      if (k < 4) req[order[k]] = 1'b1;
    end
    tick();

    // Single job, delay 10: gnt at 1, done at 16.
    do_job(4'b0001, 0, 64'd10, 15);

    // High word, counter forced to 3 when started.
    force3 = 1'b1;
    do_job(4'b1000, 3, 64'h1_0000_0002, 8);
    force3 = 1'b0;

    // Abort 20 cycles into WAIT.
    req_delay[64*2 +: 64] = 64'd1000;
    exp_gnt.push_back(4'b0100);
    push_writes(64'd1000, 1'b1);
    exp_done.push_back({4'b0100, 1'b1});
    req[2] = 1'b1;
    wait_gnt(2, n);
    check("abort_gnt_lat", 64'(n), 64'(1));
    req[2] = 1'b0;
    irq_hit = 1'b0;
    for (int c = 0; c < 23; c++) begin tick(); if (irq) irq_hit = 1'b1; end
    abort[2] = 1'b1;
    wait_done(2, n);
    check("abort_done_lat", 64'(n), 64'(2));
    abort[2] = 1'b0;
    tick(); if (irq) irq_hit = 1'b1;
    tick(); if (irq) irq_hit = 1'b1;
    check("abort_no_irq", 64'(irq_hit), 64'(0));

    // Zero delay: gnt and done together, no bus writes.
    do_job(4'b0010, 1, 64'd0, 0);

    // abort and irq in the same cycle: completion wins.
    req_delay[64*1 +: 64] = 64'd5;
    exp_gnt.push_back(4'b0010);
    push_writes(64'd5, 1'b0);
    exp_done.push_back({4'b0010, 1'b0});
    req[1] = 1'b1;
    wait_gnt(1, n);
    req[1] = 1'b0;
    repeat (8) tick();
    check("coincide_irq", 64'(irq), 64'(1));
    abort[1] = 1'b1;
    wait_done(1, n);
    check("coincide_done_lat", 64'(n), 64'(2));
    abort[1] = 1'b0;
    tick();

    // Non-owner abort is ignored.
    abort[3] = 1'b1;
    do_job(4'b0010, 1, 64'd5, 10);
    abort[3] = 1'b0;

    // Reset in WAIT, then requester 0 must beat 3.
    req_delay[64*2 +: 64] = 64'd1000;
    exp_gnt.push_back(4'b0100);
    exp_wr.push_back({2'd1, 32'd1000, 4'hF});
    exp_wr.push_back({2'd2, 32'd0, 4'hF});
    exp_wr.push_back({2'd0, 32'h1, 4'h1});
    req[2] = 1'b1;
    wait_gnt(2, n);
    req[2] = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check_quiet("midreset");
    reset = 1'b0;
    req_delay[64*3 +: 64] = 64'd5;
    do_job(4'b1001, 0, 64'd7, 12);
    do_job(4'b0000, 3, 64'd5, 10);

    repeat (3) tick();
    check("wr_q_left", 64'(exp_wr.size()), 64'(0));
    check("gnt_q_left", 64'(exp_gnt.size()), 64'(0));
    check("done_q_left", 64'(exp_done.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
